// File: rtl/divide_fix_issue_collect.sv
// divide_fix_issue_collect: issues dividend/divisor pairs to an in-order
// fixed-point divider and collects its non-backpressured results into a FIFO.
// A credit counter bounds in-flight plus buffered results, so every result
// coming back from the divider always has a free slot.
// Optional feature macro: DIVIDE_FIX_DZ_DETECT_EN (divide-by-zero flag path).
module divide_fix_issue_collect #(
  parameter int DIVIDEND_W = 40,
  parameter int DIVISOR_W  = 8,
  parameter int RESULT_W   = 64,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_req_tvalid,
  output logic                          s_req_tready,
  input  logic [DIVIDEND_W-1:0]         s_req_dividend,
  input  logic [DIVISOR_W-1:0]          s_req_divisor,
  input  logic [TAG_W-1:0]              s_req_tuser,
  output logic                          div_a_tvalid,
  output logic                          div_b_tvalid,
  output logic [DIVIDEND_W-1:0]         div_a_tdata,
  output logic [DIVISOR_W-1:0]          div_b_tdata,
  input  logic                          div_result_tvalid,
  input  logic [RESULT_W-1:0]           div_result_tdata,
  output logic                          m_res_tvalid,
  input  logic                          m_res_tready,
  output logic [RESULT_W-1:0]           m_res_tdata,
  output logic [TAG_W-1:0]              m_res_tuser,
  output logic                          m_res_dz,
  output logic [$clog2(FIFO_DEPTH):0]   credits,
  output logic                          err_unexpected
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]         credits_q, credits_d;
  logic                  div_v_q;
  logic [DIVIDEND_W-1:0] div_a_q;
  logic [DIVISOR_W-1:0]  div_b_q;
  logic                  err_q;
  logic                  issue, pop, collect, sb_empty;

  // Sideband FIFO: tag (and dz) of requests whose results are still pending
  logic [TAG_W-1:0] sb_tag_mem [FIFO_DEPTH];
  logic [AW-1:0]    sb_wr_q, sb_rd_q;
  logic [CW-1:0]    sb_cnt_q;

  // Result FIFO: collected results waiting for the downstream consumer
  logic [RESULT_W-1:0] rs_data_mem [FIFO_DEPTH];
  logic [TAG_W-1:0]    rs_tag_mem  [FIFO_DEPTH];
  logic [AW-1:0]       rs_wr_q, rs_rd_q;
  logic [CW-1:0]       rs_cnt_q;

  assign s_req_tready   = aresetn && (credits_q != '0);
  assign issue          = s_req_tvalid && s_req_tready;
  assign sb_empty       = (sb_cnt_q == '0);
  assign collect        = div_result_tvalid && !sb_empty;
  assign m_res_tvalid   = (rs_cnt_q != '0);
  assign pop            = m_res_tvalid && m_res_tready;
  assign credits        = credits_q;
  assign div_a_tvalid   = div_v_q;
  assign div_b_tvalid   = div_v_q;
  assign div_a_tdata    = div_a_q;
  assign div_b_tdata    = div_b_q;
  assign err_unexpected = err_q;
  // Head is gated by valid so outputs read zero whenever the FIFO is empty
  assign m_res_tdata    = m_res_tvalid ? rs_data_mem[rs_rd_q] : '0;
  assign m_res_tuser    = m_res_tvalid ? rs_tag_mem[rs_rd_q]  : '0;

  // Credit next state: issue takes one, output handshake returns one
  always_comb begin
    credits_d = credits_q;
    if (issue && !pop)      credits_d = credits_q - CW'(1);
    else if (!issue && pop) credits_d = credits_q + CW'(1);
  end

  // Credit register and sticky unexpected-result flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      credits_q <= CW'(FIFO_DEPTH);
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (div_result_tvalid && sb_empty) err_q <= 1'b1;
    end
  end

  // Operand register: one-cycle valid pulse per accepted request
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_v_q <= 1'b0;
      div_a_q <= '0;
      div_b_q <= '0;
    end else begin
      div_v_q <= issue;
      if (issue) begin
        div_a_q <= s_req_dividend;
        div_b_q <= s_req_divisor;
      end
    end
  end

  // FIFO pointers and occupancy for both FIFOs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sb_wr_q  <= '0;
      sb_rd_q  <= '0;
      sb_cnt_q <= '0;
      rs_wr_q  <= '0;
      rs_rd_q  <= '0;
      rs_cnt_q <= '0;
    end else begin
      if (issue)   sb_wr_q <= sb_wr_q + AW'(1);
      if (collect) sb_rd_q <= sb_rd_q + AW'(1);
      sb_cnt_q <= sb_cnt_q + CW'(issue) - CW'(collect);
      if (collect) rs_wr_q <= rs_wr_q + AW'(1);
      if (pop)     rs_rd_q <= rs_rd_q + AW'(1);
      rs_cnt_q <= rs_cnt_q + CW'(collect) - CW'(pop);
    end
  end

  // FIFO storage; credits guarantee neither FIFO is written while truly full
  always_ff @(posedge aclk) begin
    if (issue) sb_tag_mem[sb_wr_q] <= s_req_tuser;
    if (collect) begin
      rs_data_mem[rs_wr_q] <= div_result_tdata;
      rs_tag_mem[rs_wr_q]  <= sb_tag_mem[sb_rd_q];
    end
  end

`ifdef DIVIDE_FIX_DZ_DETECT_EN
  logic sb_dz_mem [FIFO_DEPTH];
  logic rs_dz_mem [FIFO_DEPTH];

  // dz travels alongside the tag through both FIFOs
  always_ff @(posedge aclk) begin
    if (issue)   sb_dz_mem[sb_wr_q] <= (s_req_divisor == '0);
    if (collect) rs_dz_mem[rs_wr_q] <= sb_dz_mem[sb_rd_q];
  end

  assign m_res_dz = m_res_tvalid ? rs_dz_mem[rs_rd_q] : 1'b0;
`else
  assign m_res_dz = 1'b0;
`endif

endmodule

// File: doc/divide_fix_issue_collect.md
# divide_fix_issue_collect

Request-side companion to the fixed-point divider wrapper (`divide_fix_wrapper_40_8`).
- Accepts dividend/divisor pairs over a valid/ready stream and issues each pair to the divider's `s_axis_a`/`s_axis_b` ports as a one-cycle pulse.
- Captures the divider's `m_axis_result` stream, which has no backpressure, and re-presents results in order on a valid/ready output, together with a caller tag.
- A credit counter bounds in-flight plus buffered results, so a divider result is never dropped under legal operation.

## Interface
Parameters:
- `DIVIDEND_W`, 40, dividend width (divider `s_axis_a_tdata`)
- `DIVISOR_W`, 8, divisor width (divider `s_axis_b_tdata`)
- `RESULT_W`, 64, divider result width, carried opaque
- `TAG_W`, 4, caller tag width
- `FIFO_DEPTH`, 16, result/sideband FIFO depth; power of 2, ≥2

Ports:
- `aclk`  in  1  single clock, rising edge
- `aresetn`  in  1  asynchronous active-low reset
- `s_req_tvalid`  in  1  request valid
- `s_req_tready`  out  1  request ready
- `s_req_dividend`  in  DIVIDEND_W  dividend
- `s_req_divisor`  in  DIVISOR_W  divisor
- `s_req_tuser`  in  TAG_W  tag
- `div_a_tvalid`, `div_b_tvalid`  out  1  divider operand valids; always driven identically
- `div_a_tdata`  out  DIVIDEND_W  to divider
- `div_b_tdata`  out  DIVISOR_W  to divider
- `div_result_tvalid`  in  1  divider result valid
- `div_result_tdata`  in  RESULT_W  divider result
- `m_res_tvalid`  out  1  result valid
- `m_res_tready`  in  1  result ready
- `m_res_tdata`  out  RESULT_W  result
- `m_res_tuser`  out  TAG_W  tag of the matching request
- `m_res_dz`  out  1  request had divisor == 0
- `credits`  out  clog2(FIFO_DEPTH)+1  free slots
- `err_unexpected`  out  1  sticky flag: a result arrived with no pending request

## Operation
- **Credits**
  - `credits = FIFO_DEPTH − (inflight + stored)`.
  - `s_req_tready = aresetn && credits != 0`. It is combinational from registered state and does not depend on `s_req_tvalid`.
- **Issue**
  - Trigger: `s_req_tvalid && s_req_tready` at an edge.
  - Next cycle: the operands are registered onto `div_*_tdata` and `div_*_tvalid` is high for exactly that cycle.
  - The same edge pushes `{tag, dz}` into the sideband FIFO, where `dz = (s_req_divisor == 0)`.
  - `credits` decrements.
- **Collect**
  - Trigger: `div_result_tvalid` with the sideband FIFO non-empty.
  - Action: pop the sideband entry and push `{div_result_tdata, tag, dz}` into the result FIFO.
  - Ordering: strictly FIFO, on the assumption that the divider completes in order.
- **Unexpected result**
  - Trigger: `div_result_tvalid` with the sideband FIFO empty.
  - Action: drop the result and set `err_unexpected`. It clears only on reset.
- **Output**
  - The result FIFO head drives `m_res_*`.
  - Each `m_res_tvalid && m_res_tready` handshake pops one entry and returns one credit. `credits` updates on the following cycle.
- **Simultaneous events**
  - Issue and pop on the same edge: `credits` is unchanged.
  - Result push and output pop on the same edge: legal at any occupancy, including full.
- **Hold rule:** `m_res_tdata`, `m_res_tuser` and `m_res_dz` are held stable while `m_res_tvalid && !m_res_tready`.
- **Reset values (`aresetn` low)**
  - Asynchronously cleared: `div_*_tvalid=0`, `div_*_tdata=0`, `m_res_tvalid=0`, `m_res_tdata=0`, `m_res_tuser=0`, `m_res_dz=0`, `err_unexpected=0`, `credits=FIFO_DEPTH`.
  - Both FIFOs are emptied.
  - `s_req_tready=0` while `aresetn` is low.
- **Reset mid-operation:** in-flight results arriving after reset release find the sideband FIFO empty, are dropped, and set `err_unexpected`.

## Timing
- **Request to divider:** request accepted at edge N → `div_*_tvalid` high in cycle N..N+1.
- **Result to output:** result at edge M into an empty result FIFO → `m_res_tvalid` high from cycle after M. No combinational path from `div_result_*` to `m_res_*`.
- **Throughput:** one request per cycle, sustained, while credits are available.
- **Latency:** divider latency is arbitrary and need not be fixed; the only requirement is in-order completion.

## Configuration
- Macro: `DIVIDE_FIX_DZ_DETECT_EN`.
- **Defined:**
  - `dz` is computed and carried through the sideband FIFO.
  - A dz request is still issued to the divider.
  - `m_res_dz` reports `dz` with its result.
- **Undefined:**
  - The `dz` logic and storage are removed.
  - `m_res_dz` is tied to 0.

## Test plan
- **Basic issue:** dividend `0x1000000000`, divisor `0x80`, tag 3.
  - `div_a_tdata=0x1000000000` and `div_b_tdata=0x80` for one cycle.
  - A driven result `0x0000_0000_2000_0000` appears on `m_res_tdata` with `m_res_tuser=3` one cycle later.
- **Backpressure to full:** hold `m_res_tready=0` and issue 16 requests; return 16 results.
  - `credits=0` and `s_req_tready=0`; a 17th request is not accepted.
  - Pulse `m_res_tready` for one cycle → `s_req_tready=1` the next cycle.
- **Ordering:** tags 0..7 back-to-back, results returned with gaps of 0–5 cycles → output tags 0..7 in order, each data value matched.
- **Divide by zero:** divisor `0x00`, tag 5.
  - Macro defined: `m_res_dz=1`.
  - Macro undefined: `m_res_dz=0`.
  - In both cases the request is issued to the divider.
- **Unexpected result:** `div_result_tvalid` pulse with no request outstanding → `err_unexpected=1`, `m_res_tvalid` stays 0, `credits=16`.
- **Reset mid-operation:** 4 requests in flight, assert `aresetn` low for 2 cycles.
  - All outputs at their reset values and `credits=16`.
  - A late result after release sets `err_unexpected`.
